// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin common-data-bus arbiter with one-entry buffers per
//            requester. Define CDB_ARB_BR_PRIO_EN to give BR_IDX absolute priority.
// Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ROB_DEPTH = 8,
    parameter int BR_IDX    = 3,
    localparam int TW       = $clog2(ROB_DEPTH),
    localparam int SW       = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*TW-1:0]   req_tag,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  cdb_valid,
    output logic [TW-1:0]         cdb_tag,
    output logic [31:0]           cdb_data,
    output logic [SW-1:0]         cdb_src
);

`ifdef CDB_ARB_BR_PRIO_EN
    localparam bit c_br_prio = 1'b1;
`else
    localparam bit c_br_prio = 1'b0;
`endif

    logic [N_REQ-1:0] r_buf_valid;
    logic [TW-1:0]    r_buf_tag  [N_REQ];
    logic [31:0]      r_buf_data [N_REQ];
    logic [SW-1:0]    r_rr;

    logic             r_cdb_valid;
    logic [TW-1:0]    r_cdb_tag;
    logic [31:0]      r_cdb_data;
    logic [SW-1:0]    r_cdb_src;

    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_accept;
    logic [SW-1:0]    w_gidx;
    logic             w_any;
    logic             w_prio;
    logic [TW-1:0]    w_tag  [N_REQ];
    logic [31:0]      w_data [N_REQ];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_req
            assign w_tag[i]     = req_tag[i*TW +: TW];
            assign w_data[i]    = req_data[i*32 +: 32];
            // A buffer being drained this cycle may refill at the same edge.
            assign req_ready[i] = !rst && !flush && (!r_buf_valid[i] || w_grant[i]);
            assign w_accept[i]  = req_valid[i] && req_ready[i];
        end
    endgenerate

    // Search from r_rr upward, wrapping; the branch override bypasses the pointer.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        w_prio  = 1'b0;
        if (c_br_prio && r_buf_valid[BR_IDX]) begin
            w_prio = 1'b1;
            w_any  = 1'b1;
            w_gidx = SW'(BR_IDX);
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_any && r_buf_valid[(int'(r_rr) + k) % N_REQ]) begin
                    w_any  = 1'b1;
                    w_gidx = SW'((int'(r_rr) + k) % N_REQ);
                end
            end
        end
        w_grant[w_gidx] = w_any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= '0;
            r_rr        <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_tag  <= r_buf_tag[w_gidx];
                r_cdb_data <= r_buf_data[w_gidx];
                r_cdb_src  <= w_gidx;
                if (!w_prio) begin
                    r_rr <= (w_gidx == SW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_tag[i]   <= w_tag[i];
                    r_buf_data[i]  <= w_data[i];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire
